status_value_queue: RTL and testbench

Registered shift-queue that stores DEPTH status entries of WIDTH bits. Head is always at entry [0] and the tail is tracked by a thermometer valid mask. Downstream consumers read the head and pull it; upstream producers push new entries at the tail. The block owns the entry registers, the valid mask, the handshakes and the occupancy count; per-entry next-state selection sits in one replicated sub-module.

---
 rtl/status_value_pkg.sv | 20 ++
 rtl/status_value_entry.sv | 80 ++++++++
 rtl/status_value_queue.sv | 120 ++++++++++++
 tb/tb_status_value_queue.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/status_value_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | status_value_pkg : shared opcodes and sizing helper for the       |
// |                    status value queue                             |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package status_value_pkg;

  // Per-cycle operation, encoded as {pull_accepted, push_accepted}
  localparam logic [1:0] NN = 2'b00;
  localparam logic [1:0] NP = 2'b01;
  localparam logic [1:0] PN = 2'b10;
  localparam logic [1:0] PP = 2'b11;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/status_value_entry.sv
`default_nettype none
// +------------------------------------------------------------------+
// | status_value_entry : one queue slot, next-value mux plus register |
// | Optional: STATUS_VALUE_SET_LAST_EN adds the overwrite-newest path |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module status_value_entry
  import status_value_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic [1:0]       op_i,
  input  logic             v_prev_i,
  input  logic             v_cur_i,
  input  logic             v_nxt_i,
  input  logic [WIDTH-1:0] push_value_i,
  input  logic [WIDTH-1:0] nbr_value_i,
`ifdef STATUS_VALUE_SET_LAST_EN
  input  logic             set_en_i,
  input  logic             nbr_tail_i,
  input  logic [WIDTH-1:0] set_value_i,
`endif
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_d;
  logic             w_tail;
  logic             w_hole;
  logic             w_set_here;
  logic             w_set_shift;
  logic [WIDTH-1:0] w_set_value;

  assign w_tail = v_cur_i & ~v_nxt_i;
  assign w_hole = ~v_cur_i & v_prev_i;

`ifdef STATUS_VALUE_SET_LAST_EN
  // set_shift: the newest entry is shifting into this slot this cycle
  assign w_set_here  = set_en_i & w_tail;
  assign w_set_shift = set_en_i & nbr_tail_i;
  assign w_set_value = set_value_i;
`else
  assign w_set_here  = 1'b0;
  assign w_set_shift = 1'b0;
  assign w_set_value = '0;
`endif

  always_comb begin
    w_d = r_q;
    case (op_i)
      NN: begin
        if (w_set_here) w_d = w_set_value;
      end
      NP: begin
        if (w_hole)          w_d = push_value_i;
        else if (w_set_here) w_d = w_set_value;
      end
      PN: begin
        w_d = w_set_shift ? w_set_value : nbr_value_i;
      end
      PP: begin
        // The old tail shifts down a slot, so the push lands where it was
        if (w_tail) w_d = push_value_i;
        else        w_d = w_set_shift ? w_set_value : nbr_value_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) r_q <= '0;
    else           r_q <= w_d;
  end

  assign q_o = r_q;

endmodule
`default_nettype wire

// File: rtl/status_value_queue.sv
`default_nettype none
// +------------------------------------------------------------------+
// | status_value_queue : head-at-0 shift queue with thermometer mask  |
// | Optional: STATUS_VALUE_SET_LAST_EN (set_i / set_value_i ports)    |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module status_value_queue
  import status_value_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     arst_n_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_value_i,
  output logic                     push_ready_o,
  input  logic                     pull_i,
  output logic                     pull_ready_o,
`ifdef STATUS_VALUE_SET_LAST_EN
  input  logic                     set_i,
  input  logic [WIDTH-1:0]         set_value_i,
`endif
  output logic [WIDTH-1:0]         head_o,
  output logic                     head_valid_o,
  output logic [DEPTH-1:0]         valid_mask_o,
  output logic [DEPTH*WIDTH-1:0]   vector_o,
  output logic [cnt_width(DEPTH)-1:0] count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int CNT_W = cnt_width(DEPTH);

  logic [DEPTH-1:0]       r_valid;
  logic [CNT_W-1:0]       r_count;
  logic [DEPTH*WIDTH-1:0] w_vector;
  logic [DEPTH*WIDTH-1:0] w_nbr;
  logic [DEPTH-1:0]       w_vprev;
  logic [DEPTH-1:0]       w_vnext;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_push_acc;
  logic                   w_pull_acc;
  logic [1:0]             w_op;

  assign w_full       = (r_count == CNT_W'(DEPTH));
  assign w_empty      = (r_count == '0);
  assign pull_ready_o = ~w_empty;
  assign push_ready_o = ~w_full | (pull_i & ~w_empty);
  assign w_push_acc   = push_i & push_ready_o;
  assign w_pull_acc   = pull_i & ~w_empty;
  assign w_op         = {w_pull_acc, w_push_acc};

  // Neighbour views of the mask; index 0 sees a virtual valid entry below it
  assign w_vprev = {r_valid[DEPTH-2:0], 1'b1};
  assign w_vnext = {1'b0, r_valid[DEPTH-1:1]};
  assign w_nbr   = w_vector >> WIDTH;

`ifdef STATUS_VALUE_SET_LAST_EN
  logic             w_set_en;
  logic [DEPTH-1:0] w_vnext2;
  logic [DEPTH-1:0] w_nbr_tail;
  assign w_set_en   = set_i & ~w_empty;
  assign w_vnext2   = r_valid >> 2;
  assign w_nbr_tail = w_vnext & ~w_vnext2;
`endif

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      status_value_entry #(
        .WIDTH (WIDTH)
      ) u_entry (
        .clk_i        (clk_i),
        .arst_n_i     (arst_n_i),
        .op_i         (w_op),
        .v_prev_i     (w_vprev[i]),
        .v_cur_i      (r_valid[i]),
        .v_nxt_i      (w_vnext[i]),
        .push_value_i (push_value_i),
        .nbr_value_i  (w_nbr[i*WIDTH +: WIDTH]),
`ifdef STATUS_VALUE_SET_LAST_EN
        .set_en_i     (w_set_en),
        .nbr_tail_i   (w_nbr_tail[i]),
        .set_value_i  (set_value_i),
`endif
        .q_o          (w_vector[i*WIDTH +: WIDTH])
      );
    end
  endgenerate

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_valid <= '0;
      r_count <= '0;
    end else begin
      case (w_op)
        NP: begin
          r_valid <= w_vprev;
          r_count <= r_count + CNT_W'(1);
        end
        PN: begin
          r_valid <= w_vnext;
          r_count <= r_count - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign head_o       = w_vector[WIDTH-1:0];
  assign head_valid_o = r_valid[0];
  assign valid_mask_o = r_valid;
  assign vector_o     = w_vector;
  assign count_o      = r_count;
  assign full_o       = w_full;
  assign empty_o      = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_status_value_queue.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_status_value_queue : directed self-checking bench              |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_status_value_queue;

  logic        clk_i = 1'b0;
  logic        arst_n_i = 1'b0;
  logic        push_i = 1'b0;
  logic [7:0]  push_value_i = '0;
  logic        push_ready_o;
  logic        pull_i = 1'b0;
  logic        pull_ready_o;
`ifdef STATUS_VALUE_SET_LAST_EN
  logic        set_i = 1'b0;
  logic [7:0]  set_value_i = '0;
`endif
  logic [7:0]  head_o;
  logic        head_valid_o;
  logic [7:0]  valid_mask_o;
  logic [63:0] vector_o;
  logic [3:0]  count_o;
  logic        full_o;
  logic        empty_o;

  int n_cmp = 0;
  int n_err = 0;

  status_value_queue #(.WIDTH(8), .DEPTH(8)) dut (
    .clk_i        (clk_i),
    .arst_n_i     (arst_n_i),
    .push_i       (push_i),
    .push_value_i (push_value_i),
    .push_ready_o (push_ready_o),
    .pull_i       (pull_i),
    .pull_ready_o (pull_ready_o),
`ifdef STATUS_VALUE_SET_LAST_EN
    .set_i        (set_i),
    .set_value_i  (set_value_i),
`endif
    .head_o       (head_o),
    .head_valid_o (head_valid_o),
    .valid_mask_o (valid_mask_o),
    .vector_o     (vector_o),
    .count_o      (count_o),
    .full_o       (full_o),
    .empty_o      (empty_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    push_i = 1'b0; pull_i = 1'b0;
`ifdef STATUS_VALUE_SET_LAST_EN
    set_i = 1'b0;
`endif
    arst_n_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    arst_n_i = 1'b1;
    step();
  endtask

  task automatic push_seq(input logic [7:0] first, input int n, input logic [7:0] inc);
    logic [7:0] v;
    v = first;
    for (int k = 0; k < n; k++) begin
      push_i = 1'b1; push_value_i = v;
      step();
      v = v + inc;
    end
    push_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (count_o !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count_o); end
    n_cmp++; if ({empty_o, full_o, head_valid_o} !== 3'b100) begin n_err++; $display("FAIL reset_flags: got %b want 100", {empty_o, full_o, head_valid_o}); end
    n_cmp++; if (vector_o !== 64'h0 || head_o !== 8'h0 || valid_mask_o !== 8'h0) begin n_err++; $display("FAIL reset_data: got vec %h head %h mask %b want zeros", vector_o, head_o, valid_mask_o); end
    n_cmp++; if ({push_ready_o, pull_ready_o} !== 2'b10) begin n_err++; $display("FAIL reset_ready: got %b want 10", {push_ready_o, pull_ready_o}); end
  endtask

  task automatic test_push_pull();
    push_seq(8'h11, 3, 8'h11);
    n_cmp++; if (count_o !== 4'd3) begin n_err++; $display("FAIL push3_count: got %0d want 3", count_o); end
    n_cmp++; if (valid_mask_o !== 8'b0000_0111) begin n_err++; $display("FAIL push3_mask: got %b want 00000111", valid_mask_o); end
    n_cmp++; if (head_o !== 8'h11 || vector_o !== 64'h0000_0000_0033_2211) begin n_err++; $display("FAIL push3_data: got head %h vec %h want 11 / 332211", head_o, vector_o); end
    pull_i = 1'b1;
    step(); step();
    n_cmp++; if (head_o !== 8'h33 || count_o !== 4'd1) begin n_err++; $display("FAIL pull2: got head %h count %0d want 33 / 1", head_o, count_o); end
    step();
    pull_i = 1'b0;
    n_cmp++; if (empty_o !== 1'b1 || vector_o !== 64'h0 || valid_mask_o !== 8'h0) begin n_err++; $display("FAIL pull3_empty: got empty %b vec %h mask %b want 1 / 0 / 0", empty_o, vector_o, valid_mask_o); end
  endtask

  task automatic test_full();
    push_seq(8'h01, 8, 8'h01);
    n_cmp++; if (full_o !== 1'b1 || count_o !== 4'd8) begin n_err++; $display("FAIL full_flag: got full %b count %0d want 1 / 8", full_o, count_o); end
    n_cmp++; if (push_ready_o !== 1'b0) begin n_err++; $display("FAIL full_push_ready: got %b want 0", push_ready_o); end
    push_i = 1'b1; push_value_i = 8'h99; pull_i = 1'b0;
    step();
    push_i = 1'b0;
    n_cmp++; if (vector_o !== 64'h0807_0605_0403_0201) begin n_err++; $display("FAIL full_reject: got %h want 0807060504030201", vector_o); end
    push_i = 1'b1; push_value_i = 8'h09; pull_i = 1'b1;
    #1;
    n_cmp++; if (push_ready_o !== 1'b1) begin n_err++; $display("FAIL full_pp_ready: got %b want 1", push_ready_o); end
    step();
    push_i = 1'b0; pull_i = 1'b0;
    n_cmp++; if (head_o !== 8'h02 || count_o !== 4'd8 || vector_o[63:56] !== 8'h09) begin n_err++; $display("FAIL full_pp: got head %h count %0d e7 %h want 02 / 8 / 09", head_o, count_o, vector_o[63:56]); end
    n_cmp++; if (vector_o !== 64'h0908_0706_0504_0302) begin n_err++; $display("FAIL full_pp_vec: got %h want 0908070605040302", vector_o); end
    do_reset();
  endtask

  task automatic test_empty_push_pull();
    push_i = 1'b1; push_value_i = 8'hAA; pull_i = 1'b1;
    #1;
    n_cmp++; if (pull_ready_o !== 1'b0 || push_ready_o !== 1'b1) begin n_err++; $display("FAIL epp_ready: got pull %b push %b want 0 / 1", pull_ready_o, push_ready_o); end
    step();
    push_i = 1'b0; pull_i = 1'b0;
    n_cmp++; if (head_o !== 8'hAA || count_o !== 4'd1 || valid_mask_o !== 8'h01) begin n_err++; $display("FAIL epp_state: got head %h count %0d mask %b want AA / 1 / 00000001", head_o, count_o, valid_mask_o); end
    pull_i = 1'b1;
    step();
    pull_i = 1'b0;
  endtask

  task automatic test_underflow();
    pull_i = 1'b1;
    step(); step();
    pull_i = 1'b0;
    n_cmp++; if (count_o !== 4'd0 || empty_o !== 1'b1 || valid_mask_o !== 8'h0 || vector_o !== 64'h0) begin n_err++; $display("FAIL underflow: got count %0d empty %b mask %b vec %h want 0 / 1 / 0 / 0", count_o, empty_o, valid_mask_o, vector_o); end
  endtask

  task automatic test_async_reset();
    push_seq(8'h5A, 3, 8'h01);
    @(posedge clk_i);
    #2;
    arst_n_i = 1'b0;
    #1;
    n_cmp++; if (count_o !== 4'd0 || valid_mask_o !== 8'h0 || vector_o !== 64'h0 || head_o !== 8'h0) begin n_err++; $display("FAIL arst_data: got count %0d mask %b vec %h head %h want zeros", count_o, valid_mask_o, vector_o, head_o); end
    n_cmp++; if ({empty_o, full_o, head_valid_o} !== 3'b100) begin n_err++; $display("FAIL arst_flags: got %b want 100", {empty_o, full_o, head_valid_o}); end
    @(negedge clk_i);
    arst_n_i = 1'b1;
    step();
  endtask

`ifdef STATUS_VALUE_SET_LAST_EN
  task automatic test_set_last();
    do_reset();
    push_seq(8'h10, 3, 8'h10);
    set_i = 1'b1; set_value_i = 8'hFF;
    step();
    set_i = 1'b0;
    n_cmp++; if (vector_o !== 64'h0000_0000_00FF_2010 || count_o !== 4'd3) begin n_err++; $display("FAIL set_only: got %h count %0d want ff2010 / 3", vector_o, count_o); end
    do_reset();
    push_seq(8'h10, 3, 8'h10);
    set_i = 1'b1; pull_i = 1'b1;
    step();
    set_i = 1'b0; pull_i = 1'b0;
    n_cmp++; if (vector_o !== 64'h0000_0000_0000_FF20 || count_o !== 4'd2) begin n_err++; $display("FAIL set_pull: got %h count %0d want ff20 / 2", vector_o, count_o); end
    do_reset();
    push_seq(8'h10, 3, 8'h10);
    set_i = 1'b1; push_i = 1'b1; push_value_i = 8'h40;
    step();
    set_i = 1'b0; push_i = 1'b0;
    n_cmp++; if (vector_o !== 64'h0000_0000_40FF_2010 || count_o !== 4'd4) begin n_err++; $display("FAIL set_push: got %h count %0d want 40ff2010 / 4", vector_o, count_o); end
    do_reset();
    push_seq(8'h10, 1, 8'h00);
    set_i = 1'b1; pull_i = 1'b1;
    step();
    set_i = 1'b0; pull_i = 1'b0;
    n_cmp++; if (vector_o !== 64'h0 || empty_o !== 1'b1) begin n_err++; $display("FAIL set_pull_last: got %h empty %b want 0 / 1", vector_o, empty_o); end
    set_i = 1'b1;
    step();
    set_i = 1'b0;
    n_cmp++; if (vector_o !== 64'h0 || count_o !== 4'd0) begin n_err++; $display("FAIL set_empty: got %h count %0d want 0 / 0", vector_o, count_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_push_pull();
    test_full();
    test_empty_push_pull();
    test_underflow();
    test_async_reset();
`ifdef STATUS_VALUE_SET_LAST_EN
    test_set_last();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
